// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier and the peripheral
// control FSM that drives it.
package mult_pkg;

    typedef enum logic [1:0] {
        MULT_IDLE,
        MULT_RUN,
        MULT_DONE
    } mult_state_t;

    localparam int MULT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per cycle.
// Optional macro MULT_EARLY_EXIT_EN ends the run once the remaining multiplier bits are all zero.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t          state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, done_q;
    logic                 lastIter;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        lastIter = 1'b0;

        case (state_q)
            MULT_IDLE, MULT_DONE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MULT_RUN;
                end
            end
            MULT_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
`ifdef MULT_EARLY_EXIT_EN
                lastIter = (cnt_q == LAST_CNT) || (mplier_d == '0);
`else
                lastIter = (cnt_q == LAST_CNT);
`endif
                if (lastIter) begin
                    state_d = MULT_DONE;
                end
            end
            default: state_d = MULT_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they are true flops
    // aligned with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MULT_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d == MULT_RUN);
            done_q   <= (state_d == MULT_DONE);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult: stimulus pushes expected results,
// a negedge monitor pops and compares when done rises.
module tb_shift_add_mult;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             accept;
        int             lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    exp_t             expQ[$];
    int               cycleCount = 0;
    int               modelFreeAt = 0;
    int               totalChecks = 0;
    int               failChecks = 0;
    logic             prevDone = 1'b0;
    logic [2*W-1:0]   lastProd = '0;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            failChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    function automatic int modelLatency(input logic [W-1:0] bV);
`ifdef MULT_EARLY_EXIT_EN
        int msb = 0;
        for (int i = 0; i < W; i++) begin
            if (bV[i]) msb = i + 1;
        end
        return (msb < 1) ? 1 : msb;
`else
        return W;
`endif
    endfunction

    // Called at a negedge while start is high for the coming edge.
    task automatic offer(input logic [W-1:0] aV, input logic [W-1:0] bV);
        exp_t e;
        if (cycleCount + 1 > modelFreeAt) begin
            e.prod   = (2*W)'(aV) * (2*W)'(bV);
            e.accept = cycleCount + 1;
            e.lat    = modelLatency(bV);
            expQ.push_back(e);
            modelFreeAt = e.accept + e.lat;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] aV, input logic [W-1:0] bV);
        @(negedge clk);
        start = 1'b1;
        a     = aV;
        b     = bV;
        offer(aV, bV);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles);
        int n = 0;
        while (!done && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneWithinBudget", 32'(done), 32'd1);
    endtask

    // Monitor: busy window, done rise/hold/fall and product against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            logic expBusy;
            expBusy = (expQ.size() > 0) && (cycleCount >= expQ[0].accept)
                      && (cycleCount < expQ[0].accept + expQ[0].lat);
            checkOutput("busy", 32'(busy), 32'(expBusy));

            if (done && !prevDone) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("product", 32'(product), 32'(e.prod));
                    checkOutput("latency", 32'(cycleCount - e.accept), 32'(e.lat));
                    lastProd = e.prod;
                end
            end else if (done && prevDone) begin
                checkOutput("productHeld", 32'(product), 32'(lastProd));
            end else if (!done && prevDone) begin
                checkOutput("doneFallOnAccept", 32'((expQ.size() > 0) && (expQ[0].accept == cycleCount)), 32'd1);
            end
            prevDone = done;
        end else begin
            prevDone = 1'b0;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetProduct", 32'(product), 32'd0);
        #2 rst_n = 1'b1;

        // Basic multiply, then done must stay asserted while idle.
        applyStimulus(8'd13, 8'd11);
        waitDone(W + 4);
        repeat (20) @(negedge clk);
        checkOutput("doneSticky", 32'(done), 32'd1);
        checkOutput("productSticky", 32'(product), 32'd143);

        applyStimulus(8'd255, 8'd255);
        waitDone(W + 4);
        checkOutput("maxProduct", 32'(product), 32'hFE01);

        applyStimulus(8'd200, 8'd0);
        waitDone(W + 4);
        applyStimulus(8'd200, 8'h80);
        waitDone(W + 4);
        applyStimulus(8'd1, 8'd1);
        waitDone(W + 4);

        // Second start lands inside the first run and must be ignored.
        applyStimulus(8'd3, 8'd5);
        repeat (1) @(negedge clk);
        applyStimulus(8'd7, 8'd7);
        waitDone(W + 4);
        repeat (W + 4) @(negedge clk);
        checkOutput("noSecondRun", 32'(product), 32'd15);

        // Asynchronous reset in the middle of a run.
        applyStimulus(8'd77, 8'hFF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncResetBusy", 32'(busy), 32'd0);
        checkOutput("asyncResetDone", 32'(done), 32'd0);
        checkOutput("asyncResetProduct", 32'(product), 32'd0);
        expQ.delete();
        modelFreeAt = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(8'd6, 8'd7);
        waitDone(W + 4);
        checkOutput("afterReset", 32'(product), 32'd42);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1;
        a     = 8'd2;
        b     = 8'd9;
        repeat (30) begin
            offer(8'd2, 8'd9);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Randomized operands with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            applyStimulus(ra, rb);
            waitDone(W + 4);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", totalChecks - failChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential shift-and-add unsigned multiplier core for the SPI multiplier peripheral. It sits directly downstream of the peripheral control FSM. That FSM raises `start` in its MULT state and waits for `done` before moving to MULTRES. This block then holds `product` stable for the MISO result buffer to shift out. It uses one cycle per multiplier bit, so a full-width multiply takes WIDTH cycles.

## Interface
- `WIDTH`, default 8: operand width in bits. Legal range 2..16. `product` is 2*WIDTH bits.
- `clk` input, 1 bit: system clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a multiply. Level-sampled on each rising edge of `clk`.
- `a` input, WIDTH bits: multiplicand. Sampled only on the accepting edge.
- `b` input, WIDTH bits: multiplier. Sampled only on the accepting edge.
- `busy` output, 1 bit: high while iterating.
- `done` output, 1 bit: sticky completion flag.
- `product` output, 2*WIDTH bits: unsigned result of a*b. Valid while `done` is high.

## Operation
- States:
  - IDLE: after reset.
  - RUN: iterating.
  - DONE: result held.
- Internal registers:
  - `mcand`, 2*WIDTH bits: multiplicand, shifted left each step.
  - `mplier`, WIDTH bits: multiplier, shifted right each step.
  - `acc`, 2*WIDTH bits: running sum.
  - `cnt`, ceil(log2 WIDTH) bits: iteration counter.
- IDLE or DONE, `start`=1: accept the request.
  - Load `mcand`={0,a}, `mplier`=b, `acc`=0, `cnt`=0.
  - Go to RUN. `done` clears on this same edge.
- IDLE, `start`=0: stay in IDLE.
- DONE, `start`=0: stay in DONE. `product` and `done` are held indefinitely.
- RUN, each edge, one iteration:
  - If `mplier[0]`, add `mcand` to `acc`. Addition is modulo 2^(2*WIDTH); overflow is impossible.
  - Shift `mcand` left by 1 and `mplier` right by 1. Increment `cnt`.
  - If `cnt`==WIDTH-1, go to DONE and set `done`=1.
- `start` seen during RUN is ignored. The request is not queued.
- `product` is driven from `acc`. It changes only during RUN, and it is cleared when a new request is accepted.
- `busy` = (state==RUN). `done` = (state==DONE). Both are registered.

## Timing
- Reset, asynchronous: state=IDLE, and `busy`, `done`, `product`, `cnt`, `mplier`, `mcand` all go to 0. This applies immediately, including mid-RUN. Any in-flight result is lost.
- Start accepted on edge k:
  - `busy` is high from after edge k to after edge k+WIDTH.
  - `done` is high from after edge k+WIDTH, with the final `product` valid on the same cycle.
- Base latency is exactly WIDTH cycles, independent of operand values.
- Back-to-back requests: `start` held high in DONE restarts on the next edge. `done` is low for exactly WIDTH cycles between results.
- `done` is a level, not a pulse. The control FSM samples it on the slower `sclk` domain, so it must stay high until the next accepted `start`.

## Configuration
- `MULT_EARLY_EXIT_EN` defined: RUN goes to DONE at the end of any iteration where the post-shift `mplier` is 0, or where `cnt`==WIDTH-1.
  - Latency becomes max(1, index of the highest set bit of b, plus 1).
  - Examples: b=0 gives 1 cycle; b=1 gives 1; b=0x80 gives 8.
- `MULT_EARLY_EXIT_EN` undefined: fixed WIDTH-cycle latency, as above.
- `product` values are identical in both builds.

## Structure
- Shared package `mult_pkg` holds:
  - state enum `mult_state_t` = {MULT_IDLE, MULT_RUN, MULT_DONE}, 2 bits;
  - constant `MULT_WIDTH_DEFAULT`=8.
- The control FSM reuses `MULT_WIDTH_DEFAULT`.
- Single module; no sub-module. The datapath is three registers plus one adder.

## Test plan
- Basic multiply: WIDTH=8, a=13, b=11, one-cycle `start`.
  - `busy` is high for 8 cycles.
  - `done` rises 8 cycles after the accepting edge, with `product`=143.
  - `done` stays high for 20 further cycles.
- Maximum operands: a=255, b=255.
  - `product`=65025 (0xFE01), with no truncation.
- Zero and early exit: a=200, b=0.
  - Early exit undefined: `product`=0, `done` after 8 cycles.
  - `MULT_EARLY_EXIT_EN` defined: `done` after 1 cycle.
  - `MULT_EARLY_EXIT_EN` defined, b=0x80: `done` after 8 cycles.
- Ignored start: pulse `start` with a=3, b=5, then pulse `start` again with a=7, b=7 at cycle 3 of RUN.
  - `product`=15 at cycle 8, and no second run follows.
- Reset mid-operation: assert `rst_n`=0 at cycle 4 of RUN.
  - `busy`, `done` and `product` go to 0 immediately, without waiting for a clock edge.
  - After release, a new request with a=6, b=7 yields 42.
- Back-to-back: hold `start`=1 continuously with a=2, b=9.
  - `done` is high for 1 cycle every 9 cycles.
  - `product`=18 on each `done` cycle.
